// File: rtl/hazard_stall_control.sv
// -----------------------------------------------------------------------------
// hazard_stall_control
//
// Hazard detection and stall unit for the 5-stage MIPS pipeline. Lives in ID
// beside the forwarding unit and handles the hazards that bypassing cannot
// resolve: load-use, branches compared in ID whose operands are still in
// flight, and reads/reissues of the multi-cycle mult/div unit. A stall holds
// PC and IF/ID and turns the ID/EX entry into a bubble. A saturating counter
// records how many cycles were lost to stalls.
//
// Ports:
//   Clk, Rst                 clock, asynchronous active-low reset
//   Rs_ID, Rt_ID             source register fields of the ID instruction
//   UsesRs_ID, UsesRt_ID     ID instruction actually reads rs / rt
//   Branch_ID                ID instruction is a branch compared in ID
//   MulDivStart_ID           ID instruction is mult/multu/div/divu
//   MfHiLo_ID                ID instruction is mfhi/mflo
//   MemRead_EX, RegWrite_EX  EX instruction is a load / writes a register
//   WriteRegAddress_EX       EX destination register
//   MemRead_MEM              MEM instruction is a load
//   WriteRegAddress_MEM      MEM destination register
//   PCWrite, IFIDWrite       enables, low while stalling
//   IDEXFlush                bubble into ID/EX
//   Stall                    stall asserted this cycle
//   MulDivBusy, MulDivDone   mult/div busy, pulse on its last busy cycle
//   StallCycles              saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_stall_control #(
  parameter int MULDIV_LATENCY = 32,
  parameter int CNT_W          = 6,
  parameter int PERF_W         = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [4:0]        Rs_ID,
  input  logic [4:0]        Rt_ID,
  input  logic              UsesRs_ID,
  input  logic              UsesRt_ID,
  input  logic              Branch_ID,
  input  logic              MulDivStart_ID,
  input  logic              MfHiLo_ID,
  input  logic              MemRead_EX,
  input  logic              RegWrite_EX,
  input  logic [4:0]        WriteRegAddress_EX,
  input  logic              MemRead_MEM,
  input  logic [4:0]        WriteRegAddress_MEM,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IDEXFlush,
  output logic              Stall,
  output logic              MulDivBusy,
  output logic              MulDivDone,
  output logic [PERF_W-1:0] StallCycles
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // Countdown value loaded on issue so that the unit is busy for exactly
  // MULDIV_LATENCY cycles, the last one being the cnt==0 cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LATENCY - 1);

  md_state_t        state;
  md_state_t        next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;

  logic rs_match_ex;
  logic rt_match_ex;
  logic rs_match_mem;
  logic rt_match_mem;
  logic load_use;
  logic br_ex;
  logic br_mem;
  logic md_hazard;
  logic raw_stall;
  logic raw_done;

  // Operand matches; $zero is never a real dependency.
  always_comb begin
    rs_match_ex  = UsesRs_ID && (Rs_ID != 5'd0) && (Rs_ID == WriteRegAddress_EX);
    rt_match_ex  = UsesRt_ID && (Rt_ID != 5'd0) && (Rt_ID == WriteRegAddress_EX);
    rs_match_mem = UsesRs_ID && (Rs_ID != 5'd0) && (Rs_ID == WriteRegAddress_MEM);
    rt_match_mem = UsesRt_ID && (Rt_ID != 5'd0) && (Rt_ID == WriteRegAddress_MEM);

    load_use  = MemRead_EX && (rs_match_ex || rt_match_ex);
    br_ex     = Branch_ID && RegWrite_EX && (rs_match_ex || rt_match_ex);
    br_mem    = Branch_ID && MemRead_MEM && (rs_match_mem || rt_match_mem);
    md_hazard = (state == BUSY) && (MulDivStart_ID || MfHiLo_ID);

    raw_stall = load_use || br_ex || br_mem || md_hazard;
  end

  // Mult/div next-state logic. An issue is only accepted when nothing else
  // stalls the ID instruction, otherwise it is simply retried next cycle.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    raw_done   = 1'b0;
    case (state)
      IDLE: begin
        if (MulDivStart_ID && !raw_stall) begin
          next_state = BUSY;
          next_cnt   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          raw_done   = 1'b1;
          next_state = IDLE;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Saturating stall counter: holds at all-ones instead of wrapping.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      StallCycles <= '0;
    end else if (raw_stall && (StallCycles != '1)) begin
      StallCycles <= StallCycles + PERF_W'(1);
    end
  end

  // While in reset the pipeline is frozen with a bubble in ID/EX, but no
  // stall is reported.
  always_comb begin
    Stall      = Rst && raw_stall;
    PCWrite    = Rst && !raw_stall;
    IFIDWrite  = Rst && !raw_stall;
    IDEXFlush  = !Rst || raw_stall;
    MulDivBusy = Rst && (state == BUSY);
    MulDivDone = Rst && raw_done;
  end

endmodule

// File: tb/tb_hazard_stall_control.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_control
//
// Self-checking bench for hazard_stall_control (MULDIV_LATENCY=4, CNT_W=2,
// PERF_W=4). Directed scenarios followed by randomized stimulus with random
// asynchronous resets, all compared against a behavioural model that tracks
// the mult/div unit as "cycles of busy left" and the stall count as an
// integer clamped at 15.
// -----------------------------------------------------------------------------
module tb_hazard_stall_control;

  localparam int LAT      = 4;
  localparam int PERF_MAX = 15;

  logic       Clk;
  logic       Rst;
  logic [4:0] rsId;
  logic [4:0] rtId;
  logic       usesRsId;
  logic       usesRtId;
  logic       branchId;
  logic       mdStartId;
  logic       mfHiLoId;
  logic       memReadEx;
  logic       regWriteEx;
  logic [4:0] wrEx;
  logic       memReadMem;
  logic [4:0] wrMem;
  logic       pcWrite;
  logic       ifIdWrite;
  logic       idExFlush;
  logic       stall;
  logic       mdBusy;
  logic       mdDone;
  logic [3:0] stallCycles;

  int checkCount = 0;
  int errorCount = 0;
  int mdRemain   = 0;
  int perfCount  = 0;
  int perfBase   = 0;

  hazard_stall_control #(
    .MULDIV_LATENCY(LAT),
    .CNT_W(2),
    .PERF_W(4)
  ) dut (
    .Clk                (Clk),
    .Rst                (Rst),
    .Rs_ID              (rsId),
    .Rt_ID              (rtId),
    .UsesRs_ID          (usesRsId),
    .UsesRt_ID          (usesRtId),
    .Branch_ID          (branchId),
    .MulDivStart_ID     (mdStartId),
    .MfHiLo_ID          (mfHiLoId),
    .MemRead_EX         (memReadEx),
    .RegWrite_EX        (regWriteEx),
    .WriteRegAddress_EX (wrEx),
    .MemRead_MEM        (memReadMem),
    .WriteRegAddress_MEM(wrMem),
    .PCWrite            (pcWrite),
    .IFIDWrite          (ifIdWrite),
    .IDEXFlush          (idExFlush),
    .Stall              (stall),
    .MulDivBusy         (mdBusy),
    .MulDivDone         (mdDone),
    .StallCycles        (stallCycles)
  );

  // 10-time-unit clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt,
                               input logic br, input logic mds, input logic mf,
                               input logic mrex, input logic rwex,
                               input logic [4:0] wex, input logic mrmem,
                               input logic [4:0] wmem);
    rsId       = rs;
    rtId       = rt;
    usesRsId   = urs;
    usesRtId   = urt;
    branchId   = br;
    mdStartId  = mds;
    mfHiLoId   = mf;
    memReadEx  = mrex;
    regWriteEx = rwex;
    wrEx       = wex;
    memReadMem = mrmem;
    wrMem      = wmem;
  endtask

  task automatic clearInputs();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  function automatic bit depends(input logic [4:0] src, input logic uses,
                                 input logic [4:0] dst);
    return uses && (src != 0) && (src == dst);
  endfunction

  // Hazard rules evaluated on the current inputs and model state.
  function automatic bit modelStall();
    bit needEx;
    bit needMem;
    needEx  = depends(rsId, usesRsId, wrEx)  || depends(rtId, usesRtId, wrEx);
    needMem = depends(rsId, usesRsId, wrMem) || depends(rtId, usesRtId, wrMem);
    return (memReadEx && needEx) ||
           (branchId && regWriteEx && needEx) ||
           (branchId && memReadMem && needMem) ||
           ((mdRemain > 0) && (mdStartId || mfHiLoId));
  endfunction

  task automatic modelReset();
    mdRemain  = 0;
    perfCount = 0;
  endtask

  // Outputs expected while reset is held low.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_pcw"},   {31'd0, pcWrite},   32'd0);
    checkOutput({tag, "_ifid"},  {31'd0, ifIdWrite}, 32'd0);
    checkOutput({tag, "_flush"}, {31'd0, idExFlush}, 32'd1);
    checkOutput({tag, "_stall"}, {31'd0, stall},     32'd0);
    checkOutput({tag, "_busy"},  {31'd0, mdBusy},    32'd0);
    checkOutput({tag, "_done"},  {31'd0, mdDone},    32'd0);
    checkOutput({tag, "_cnt"},   {28'd0, stallCycles}, 32'd0);
  endtask

  // One clock cycle: check at the falling edge, advance the model on the
  // rising edge, return 1 time unit after it.
  task automatic runCycle(input string tag);
    bit expStall;
    @(negedge Clk);
    expStall = modelStall();
    checkOutput({tag, "_pcw"},   {31'd0, pcWrite},   {31'd0, !expStall});
    checkOutput({tag, "_ifid"},  {31'd0, ifIdWrite}, {31'd0, !expStall});
    checkOutput({tag, "_flush"}, {31'd0, idExFlush}, {31'd0, expStall});
    checkOutput({tag, "_stall"}, {31'd0, stall},     {31'd0, expStall});
    checkOutput({tag, "_busy"},  {31'd0, mdBusy},    {31'd0, mdRemain > 0});
    checkOutput({tag, "_done"},  {31'd0, mdDone},    {31'd0, mdRemain == 1});
    checkOutput({tag, "_cnt"},   {28'd0, stallCycles}, perfCount);
    @(posedge Clk);
    if (expStall && perfCount < PERF_MAX) perfCount++;
    if (mdRemain > 0) mdRemain--;
    else if (mdStartId && !expStall) mdRemain = LAT;
    #1;
  endtask

  initial begin
    Rst = 1'b0;
    clearInputs();
    #2;
    checkResetOutputs("rst");
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    modelReset();

    // Load-use on rs, then the same with $zero as the destination.
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
    runCycle("lu");
    checkOutput("lu_count", {28'd0, stallCycles}, 32'd1);
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0);
    runCycle("lu0");
    checkOutput("lu0_stall", {31'd0, stall}, 32'd0);

    // Branch on rt=8: ALU producer in EX, then load in MEM, then non-load in MEM.
    applyStimulus(5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0);
    runCycle("brex");
    applyStimulus(5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8);
    runCycle("brmem");
    checkOutput("brmem_stall", {31'd0, stall}, 32'd1);
    applyStimulus(5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd8);
    runCycle("brnl");
    checkOutput("brnl_stall", {31'd0, stall}, 32'd0);
    checkOutput("br_count", {28'd0, stallCycles}, 32'd3);

    // Mult/div: start at cycle 0, mflo held in ID from cycle 2.
    clearInputs();
    mdStartId = 1'b1;
    runCycle("md0");
    clearInputs();
    runCycle("md1");
    checkOutput("md1_busy", {31'd0, mdBusy}, 32'd1);
    perfBase = perfCount;
    mfHiLoId = 1'b1;
    runCycle("md2");
    runCycle("md3");
    checkOutput("md4_done", {31'd0, mdDone}, 32'd1);
    runCycle("md4");
    checkOutput("md5_busy",  {31'd0, mdBusy}, 32'd0);
    checkOutput("md5_stall", {31'd0, stall},  32'd0);
    checkOutput("md_count", {28'd0, stallCycles}, perfBase + 3);
    runCycle("md5");

    // Start blocked by a load-use on its operand, then retried cleanly.
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
    runCycle("blk");
    checkOutput("blk_busy", {31'd0, mdBusy}, 32'd0);
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    runCycle("retry");
    checkOutput("retry_busy", {31'd0, mdBusy}, 32'd1);
    clearInputs();
    runCycle("retry1");

    // Now at cnt==2: asynchronous reset mid-BUSY.
    Rst = 1'b0;
    #1;
    modelReset();
    checkResetOutputs("rstmid");
    @(posedge Clk);
    #1;
    checkResetOutputs("rsthold");
    Rst = 1'b1;
    #1;
    checkOutput("rel_pcw",   {31'd0, pcWrite},   32'd1);
    checkOutput("rel_flush", {31'd0, idExFlush}, 32'd0);
    runCycle("rel");

    // Saturation: 20 consecutive load-use stalls.
    applyStimulus(5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0);
    for (int i = 0; i < 20; i++) runCycle("sat");
    checkOutput("sat_count", {28'd0, stallCycles}, 32'd15);

    // Randomized stimulus with occasional asynchronous resets.
    Rst = 1'b0;
    #1;
    modelReset();
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom),
                    1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 2),
                    1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 9) < 3),
                    1'($urandom), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 3)));
      if ($urandom_range(0, 59) == 0) begin
        Rst = 1'b0;
        #1;
        modelReset();
        checkResetOutputs("rnd_rst");
        @(posedge Clk);
        #1;
        Rst = 1'b1;
      end else begin
        runCycle("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
